// File: rtl/mips_avalon_bridge.sv
// Avalon-MM bridge from the mips_cpu_bus master to the 64 KiB RAM: address
// translation, range/alignment rejection, inserted wait states, error/transaction stats.
// Optional BRIDGE_RANDOM_WAIT_EN: per-request wait count drawn from a 16-bit LFSR.
module mips_avalon_bridge #(
    parameter logic [31:0] BASE        = 32'hBFC00000,
    parameter logic [31:0] SPAN        = 32'h00010000,
    parameter logic [31:0] WAIT_CYCLES = 32'd3,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    input  logic [3:0]  cpu_byteenable,
    output logic        cpu_waitrequest,
    output logic [31:0] cpu_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        err,
    output logic [31:0] err_address,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);
    typedef enum logic [1:0] {IDLE, DELAY, ISSUE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [3:0]  be_q, be_d;
    logic        wr_q, wr_d, rej_q, rej_d, err_q, err_d;
    logic [15:0] delay_q, delay_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [15:0] delay_load;
    logic [31:0] offset;
    logic        req_bad;

`ifdef BRIDGE_RANDOM_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign delay_load = lfsr_q & WAIT_CYCLES[15:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign delay_load = WAIT_CYCLES[15:0];
`endif

    assign offset  = cpu_address - BASE;
    assign req_bad = (cpu_address < BASE) || (offset >= SPAN) ||
                     (cpu_address[1:0] != 2'b00) || (cpu_read && cpu_write);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        rej_d      = rej_q;
        rdata_d    = rdata_q;
        delay_d    = delay_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        case (state_q)
            IDLE: if (cpu_read || cpu_write) begin
                addr_d  = cpu_address;
                wdata_d = cpu_writedata;
                be_d    = cpu_byteenable;
                // a read+write collision is treated as a read so it returns ERR_DATA
                wr_d    = cpu_write && !cpu_read;
                rej_d   = req_bad;
                if (req_bad) begin
                    state_d = RESP;
                    if (cpu_read) rdata_d = ERR_DATA;
                end else if (delay_load == 16'd0) begin
                    state_d = ISSUE;
                end else begin
                    delay_d = delay_load;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (delay_q == 16'd0) state_d = ISSUE;
                else                  delay_d = delay_q - 16'd1;
            end
            ISSUE: if (!mem_waitrequest) begin
                if (!wr_q) rdata_d = mem_readdata;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (rej_q) begin
                    if (!err_q) begin
                        err_d      = 1'b1;
                        err_addr_d = addr_q;
                    end
                end else if (wr_q) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            wr_q       <= 1'b0;
            rej_q      <= 1'b0;
            rdata_q    <= '0;
            delay_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            wr_q       <= wr_d;
            rej_q      <= rej_d;
            rdata_q    <= rdata_d;
            delay_q    <= delay_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // strobes decode straight from state so an async reset kills them at once
    assign cpu_waitrequest = (state_q != RESP);
    assign cpu_readdata    = rdata_q;
    assign mem_read        = (state_q == ISSUE) && !wr_q;
    assign mem_write       = (state_q == ISSUE) && wr_q;
    assign mem_address     = addr_q - BASE;
    assign mem_writedata   = wdata_q;
    assign mem_byteenable  = be_q;
    assign err             = err_q;
    assign err_address     = err_addr_q;
    assign rd_count        = rd_cnt_q;
    assign wr_count        = wr_cnt_q;
endmodule

// File: doc/mips_avalon_bridge.md
Name: mips_avalon_bridge

Overview:
- Avalon-MM bridge between the mips_cpu_bus master port and the 64 KiB RAM slave.
- Translates CPU physical addresses into the RAM's 16-bit simulated window (address − BASE) and range/alignment-checks each request.
- Inserts a configurable number of wait states, so the CPU's waitrequest handling is exercised beyond what the RAM alone produces.
- Sticky error flag and transaction counters give benches pass/fail evidence without bus-level scraping.

Parameters:
- BASE, 32'hBFC00000, first CPU address mapped to RAM word 0.
- SPAN, 32'h00010000, window size in bytes; valid range is [BASE, BASE+SPAN-1].
- WAIT_CYCLES, 3, wait states inserted before each RAM access. In random mode it is a mask and must be 2^n−1.
- ERR_DATA, 32'hDEADBEEF, cpu_readdata returned for a rejected read.
- LFSR_SEED, 16'hACE1, LFSR reset value. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_address  in  32  CPU byte address.
- cpu_read  in  1  CPU read request.
- cpu_write  in  1  CPU write request.
- cpu_writedata  in  32  write data.
- cpu_byteenable  in  4  byte lanes.
- cpu_waitrequest  out  1  stall to the CPU.
- cpu_readdata  out  32  read data to the CPU.
- mem_address  out  32  translated address: cpu_address − BASE.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_writedata  out  32  latched write data.
- mem_byteenable  out  4  latched byte lanes.
- mem_waitrequest  in  1  RAM stall.
- mem_readdata  in  32  RAM read data.
- err  out  1  sticky: at least one request was rejected.
- err_address  out  32  cpu_address of the first rejected request.
- rd_count  out  16  completed reads; wraps at 16'hFFFF→0.
- wr_count  out  16  completed writes; wraps at 16'hFFFF→0.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE; mem_read = mem_write = 0; cpu_readdata = 0.
  - err = 0; err_address = 0; rd_count = wr_count = 0; delay counter = 0.
  - No partial RAM write may complete after reset asserts.
- cpu_waitrequest is combinational: low only in RESP. Otherwise high, including IDLE.
- States:
  - IDLE: on a rising edge with cpu_read | cpu_write, latch address, writedata, byteenable and direction.
    - A request is rejected if it is out of range, not word-aligned (address[1:0] ≠ 0), or has cpu_read and cpu_write both high.
    - Rejected → RESP with reject flag set. Otherwise load delay = WAIT_CYCLES and go to DELAY, or directly to ISSUE when delay = 0.
  - DELAY: decrement delay each cycle; go to ISSUE on the cycle delay reaches 0. mem_read and mem_write stay 0.
  - ISSUE: drive mem_* from the latched values, holding them stable while mem_waitrequest = 1.
    - On the edge where mem_waitrequest = 0: capture mem_readdata (reads only), deassert the strobe, go to RESP.
  - RESP: one cycle with cpu_waitrequest = 0, then IDLE.
    - cpu_readdata = captured data, or ERR_DATA for a rejected read.
    - Increment rd_count or wr_count for non-rejected transactions only.
    - On the first rejection set err and err_address; later rejections do not overwrite err_address.
- Latency with fixed waits and RAM waitrequest low (W = WAIT_CYCLES): cpu_waitrequest is high for exactly W+2 cycles after the request edge, then low for 1 cycle.
- Back-to-back: if the CPU keeps the strobe high after RESP, IDLE accepts it as a new request on the next edge. No request may be double-counted.
- Inputs changing mid-transaction are ignored; latched values govern.
- cpu_readdata holds its last value outside RESP.

Optional Feature:
- Macro: BRIDGE_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle from LFSR_SEED.
  - Delay loaded in IDLE = lfsr[15:0] & WAIT_CYCLES, giving random 0..WAIT_CYCLES waits reproducible from the seed.
- Undefined: no LFSR logic; delay = WAIT_CYCLES always.

Test Plan:
- Read 32'hBFC00010, W=3, RAM returns 32'h12345678 with no wait → cpu_waitrequest high 5 cycles, then low 1 cycle with cpu_readdata = 32'h12345678; mem_address = 32'h10; rd_count = 1.
- Write 32'hBFC00020, data 32'hCAFEF00D, byteenable 4'b0011, RAM stalls 2 cycles → mem_write held 3 cycles with stable data/byteenable; completes; wr_count = 1; err = 0.
- Read 32'h00000004 → no mem_read; RESP with cpu_readdata = 32'hDEADBEEF; err = 1; err_address = 32'h00000004; rd_count unchanged.
- Misaligned write to 32'hBFC00002, then read+write together at 32'hBFC00100 → both rejected; err_address stays 32'hBFC00002.
- Assert reset during ISSUE of a write → mem_write drops in the same cycle without waiting for an edge; all counters and err are 0; the next read completes normally.
- With BRIDGE_RANDOM_WAIT_EN, WAIT_CYCLES=3: 100 back-to-back reads → every delay is in 0..3, the delay sequence matches a reference LFSR model, and rd_count = 100.
